// File: rtl/agex_muldiv_ctrl_pkg.sv
// Shared types and constants for the AGEX-side iterative RV32M multiply/divide unit.
package agex_muldiv_ctrl_pkg;

    localparam int unsigned DBITS     = 32;
    localparam int unsigned PBITS     = 2 * DBITS;
    localparam int unsigned REGNOBITS = 5;
    localparam int unsigned CNTBITS   = 6;
    localparam int unsigned OPBITS    = 3;

    typedef enum logic [OPBITS-1:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } muldiv_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } muldiv_state_e;

    localparam logic [DBITS-1:0] DIV_ZERO_Q = {DBITS{1'b1}};
    localparam logic [DBITS-1:0] DIV_OVF_Q  = {1'b1, {(DBITS-1){1'b0}}};

    function automatic logic op_a_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_b_signed(input muldiv_op_e op);
        return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
    endfunction

    function automatic logic op_is_div(input muldiv_op_e op);
        return (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/agex_muldiv_ctrl_if.sv
// Request/response handshake bundle between AGEX and the multiply/divide unit.
interface agex_muldiv_ctrl_if;
    import agex_muldiv_ctrl_pkg::*;

    logic                 req_valid;
    logic                 req_ready;
    logic [OPBITS-1:0]    req_op;
    logic [DBITS-1:0]     req_a;
    logic [DBITS-1:0]     req_b;
    logic [REGNOBITS-1:0] req_wregno;
    logic                 resp_valid;
    logic                 resp_ready;
    logic [DBITS-1:0]     resp_result;
    logic [REGNOBITS-1:0] resp_wregno;

    modport master (
        output req_valid, req_op, req_a, req_b, req_wregno, resp_ready,
        input  req_ready, resp_valid, resp_result, resp_wregno
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_wregno, resp_ready,
        output req_ready, resp_valid, resp_result, resp_wregno
    );
endinterface

// File: rtl/agex_muldiv_ctrl_iter_dp.sv
// Iterative datapath: shift-add multiply and restoring divide on operand magnitudes,
// one add/subtract per step, sign fix-up and word select on the final step.
module muldiv_iter_dp
    import agex_muldiv_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             i_load,
    input  logic             i_step,
    input  logic             i_finish,
    input  muldiv_op_e       i_op,
    input  logic [DBITS-1:0] i_a,
    input  logic [DBITS-1:0] i_b,
    input  logic             i_special,
    input  logic [DBITS-1:0] i_special_val,
    output logic [DBITS-1:0] o_result
);

    // r_hi: product high half / partial remainder; r_lo: multiplier / quotient bits
    logic [DBITS:0]   r_hi;
    logic [DBITS-1:0] r_lo, r_b, r_result;
    muldiv_op_e       r_op;
    logic             r_sign_a, r_sign_b;

    logic             w_sign_a, w_sign_b, w_is_div, w_borrow;
    logic [DBITS-1:0] w_mag_a, w_mag_b, w_lo_nxt, w_quo_s, w_rem_s, w_final;
    logic [DBITS:0]   w_shift, w_addsub, w_mhi, w_hi_nxt;
    logic [PBITS-1:0] w_prod, w_prod_s;

    assign w_sign_a = i_a[DBITS-1] & op_a_signed(i_op);
    assign w_sign_b = i_b[DBITS-1] & op_b_signed(i_op);
    assign w_mag_a  = w_sign_a ? (~i_a + DBITS'(1)) : i_a;
    assign w_mag_b  = w_sign_b ? (~i_b + DBITS'(1)) : i_b;

    assign w_is_div = op_is_div(r_op);
    assign w_shift  = {r_hi[DBITS-1:0], r_lo[DBITS-1]};
    assign w_addsub = w_is_div ? (w_shift - {1'b0, r_b}) : (r_hi + {1'b0, r_b});
    assign w_borrow = w_addsub[DBITS];
    assign w_mhi    = r_lo[0] ? w_addsub : r_hi;

    always_comb begin
        w_hi_nxt = {1'b0, w_mhi[DBITS:1]};
        w_lo_nxt = {w_mhi[0], r_lo[DBITS-1:1]};
        if (w_is_div) begin
            w_hi_nxt = w_borrow ? w_shift : w_addsub;
            w_lo_nxt = {r_lo[DBITS-2:0], ~w_borrow};
        end
    end

    assign w_prod   = {w_hi_nxt[DBITS-1:0], w_lo_nxt};
    assign w_prod_s = (r_sign_a ^ r_sign_b) ? (~w_prod + PBITS'(1)) : w_prod;
    assign w_quo_s  = (r_sign_a ^ r_sign_b) ? (~w_lo_nxt + DBITS'(1)) : w_lo_nxt;
    assign w_rem_s  = r_sign_a ? (~w_hi_nxt[DBITS-1:0] + DBITS'(1)) : w_hi_nxt[DBITS-1:0];

    always_comb begin
        w_final = w_rem_s;
        case (r_op)
            OP_MUL:                        w_final = w_prod_s[DBITS-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  w_final = w_prod_s[PBITS-1:DBITS];
            OP_DIV, OP_DIVU:               w_final = w_quo_s;
            default:                       w_final = w_rem_s;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_hi     <= '0;
            r_lo     <= '0;
            r_b      <= '0;
            r_op     <= OP_MUL;
            r_sign_a <= 1'b0;
            r_sign_b <= 1'b0;
            r_result <= '0;
        end else if (i_load) begin
            r_hi     <= '0;
            r_lo     <= w_mag_a;
            r_b      <= w_mag_b;
            r_op     <= i_op;
            r_sign_a <= w_sign_a;
            r_sign_b <= w_sign_b;
            if (i_special) r_result <= i_special_val;
        end else if (i_step) begin
            r_hi <= w_hi_nxt;
            r_lo <= w_lo_nxt;
            if (i_finish) r_result <= w_final;
        end
    end

    assign o_result = r_result;

endmodule

// File: rtl/agex_muldiv_ctrl.sv
// RV32M sequencing controller: accepts one op at a time, runs the iterative datapath,
// holds the result until taken, and aborts on flush.
module agex_muldiv_ctrl
    import agex_muldiv_ctrl_pkg::*;
(
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     flush,
    output logic                     busy,
    agex_muldiv_ctrl_if.slave        bus
);

    muldiv_state_e        r_state, w_state_nxt;
    logic [CNTBITS-1:0]   r_cnt;
    logic [REGNOBITS-1:0] r_wregno;
    logic                 r_req_ready, r_busy, r_resp_valid;
    logic                 w_accept, w_load, w_step, w_finish;
    logic                 w_b_zero, w_ovf, w_special;
    logic [DBITS-1:0]     w_special_val, w_result;
    muldiv_op_e           w_op;

    assign w_op     = muldiv_op_e'(bus.req_op);
    assign w_accept = bus.req_valid && (r_state == ST_IDLE) && !flush;

    // Divide-by-zero and signed overflow finish without iterating
    assign w_b_zero  = (bus.req_b == '0);
    assign w_ovf     = !bus.req_op[0] && (bus.req_a == DIV_OVF_Q) && (bus.req_b == DIV_ZERO_Q);
    assign w_special = op_is_div(w_op) && (w_b_zero || w_ovf);

    always_comb begin
        w_special_val = '0;
        if (w_b_zero) w_special_val = bus.req_op[1] ? bus.req_a : DIV_ZERO_Q;
        else          w_special_val = bus.req_op[1] ? '0 : DIV_OVF_Q;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_step      = 1'b0;
        w_finish    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_load      = 1'b1;
                    w_state_nxt = w_special ? ST_DONE : ST_CALC;
                end
            end
            ST_CALC: begin
                w_step = 1'b1;
                if (r_cnt == CNTBITS'(DBITS - 1)) begin
                    w_finish    = 1'b1;
                    w_state_nxt = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.resp_ready) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (flush) begin
            w_state_nxt = ST_IDLE;
            w_step      = 1'b0;
            w_finish    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= ST_IDLE;
            r_req_ready  <= 1'b1;
            r_busy       <= 1'b0;
            r_resp_valid <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_req_ready  <= (w_state_nxt == ST_IDLE);
            r_busy       <= (w_state_nxt != ST_IDLE);
            r_resp_valid <= (w_state_nxt == ST_DONE);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cnt    <= '0;
            r_wregno <= '0;
        end else if (w_load) begin
            r_cnt    <= '0;
            r_wregno <= bus.req_wregno;
        end else if (w_step) begin
            r_cnt <= r_cnt + CNTBITS'(1);
        end
    end

    muldiv_iter_dp u_dp (
        .clk           (clk),
        .reset         (reset),
        .i_load        (w_load),
        .i_step        (w_step),
        .i_finish      (w_finish),
        .i_op          (w_op),
        .i_a           (bus.req_a),
        .i_b           (bus.req_b),
        .i_special     (w_special),
        .i_special_val (w_special_val),
        .o_result      (w_result)
    );

    assign bus.req_ready   = r_req_ready;
    assign bus.resp_valid  = r_resp_valid;
    assign bus.resp_result = w_result;
    assign bus.resp_wregno = r_wregno;
    assign busy            = r_busy;

endmodule

// File: tb/tb_agex_muldiv_ctrl.sv
// Bench for agex_muldiv_ctrl: directed ops with literal expectations plus a
// cycle-level reference model checked against the DUT on every falling edge.
module tb_agex_muldiv_ctrl;
    import agex_muldiv_ctrl_pkg::*;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    logic flush = 1'b0;
    logic busy;

    agex_muldiv_ctrl_if bus();

    agex_muldiv_ctrl dut (
        .clk   (clk),
        .reset (rst_n),
        .flush (flush),
        .busy  (busy),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;
    int cyc = 0;
    int t_acc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    endtask

    // Architectural result of an RV32M op from plain signed/unsigned arithmetic
    function automatic logic [31:0] ref_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub, p;
        int ia, ib;
        logic [63:0] pv;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ua = longint'({32'b0, a});
        ub = longint'({32'b0, b});
        ia = $signed(a);
        ib = $signed(b);
        p  = 0;
        case (op)
            3'd0: p = sa * sb;
            3'd1: p = sa * sb;
            3'd2: p = sa * ub;
            3'd3: p = ua * ub;
            default: p = 0;
        endcase
        pv = p;
        case (op)
            3'd0: return pv[31:0];
            3'd1, 3'd2, 3'd3: return pv[63:32];
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
                return 32'(ia / ib);
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
                return 32'(ia % ib);
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic bit ref_fast(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bit is_div, signed_div;
        is_div     = (op >= 3'd4);
        signed_div = (op == 3'd4) || (op == 3'd6);
        return is_div && ((b == 0) || (signed_div && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
    endfunction

    // Reference model: occupancy, cycles until the result, and the response itself
    bit          m_busy  = 1'b0;
    bit          m_valid = 1'b0;
    int          m_left  = 0;
    logic [31:0] m_res   = '0;
    logic [4:0]  m_wr    = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
            m_res   = '0;
            m_wr    = '0;
        end else if (flush) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end else if (!m_busy && bus.req_valid) begin
            m_busy  = 1'b1;
            m_res   = ref_op(bus.req_op, bus.req_a, bus.req_b);
            m_wr    = bus.req_wregno;
            m_valid = ref_fast(bus.req_op, bus.req_a, bus.req_b);
            m_left  = 32;
        end else if (m_busy && !m_valid) begin
            m_left--;
            if (m_left == 0) m_valid = 1'b1;
        end else if (m_valid && bus.resp_ready) begin
            m_busy  = 1'b0;
            m_valid = 1'b0;
        end
    end

    always @(negedge clk) begin
        chk("cmp_busy", 32'(busy), 32'(m_busy));
        chk("cmp_req_ready", 32'(bus.req_ready), 32'(!m_busy));
        chk("cmp_resp_valid", 32'(bus.resp_valid), 32'(m_valid));
        if (m_valid) begin
            chk("cmp_resp_result", bus.resp_result, m_res);
            chk("cmp_resp_wregno", 32'(bus.resp_wregno), 32'(m_wr));
        end
    end

    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] wr);
        bus.req_op     = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_wregno = wr;
        bus.req_valid  = 1'b1;
        @(posedge clk); #1;
        bus.req_valid  = 1'b0;
        t_acc          = cyc;
    endtask

    task automatic wait_resp(input string nm, input logic [31:0] exp, input logic [4:0] wr,
                             input int lat);
        int k;
        k = 0;
        while (!bus.resp_valid && k < 100) begin
            @(posedge clk); #1;
            k++;
        end
        if (!bus.resp_valid) begin
            n_chk++;
            $display("FAIL %s_timeout: resp_valid stayed 0, expected 1 within 100 cycles", nm);
            return;
        end
        chk({nm, "_result"}, bus.resp_result, exp);
        chk({nm, "_wregno"}, 32'(bus.resp_wregno), 32'(wr));
        chk({nm, "_latency"}, 32'(cyc - t_acc + 1), 32'(lat));
        if (bus.resp_ready) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic run(input string nm, input logic [2:0] op, input logic [31:0] a,
                       input logic [31:0] b, input logic [4:0] wr, input logic [31:0] exp,
                       input int lat);
        start_op(op, a, b, wr);
        wait_resp(nm, exp, wr, lat);
    endtask

    initial begin
        bus.req_valid  = 1'b0;
        bus.req_op     = '0;
        bus.req_a      = '0;
        bus.req_b      = '0;
        bus.req_wregno = '0;
        bus.resp_ready = 1'b1;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_req_ready", 32'(bus.req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_resp_valid", 32'(bus.resp_valid), 32'd0);
        chk("rst_resp_result", bus.resp_result, 32'd0);
        chk("rst_resp_wregno", 32'(bus.resp_wregno), 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;

        run("mul_7_m3",     OP_MUL,    32'd7,         32'hFFFF_FFFD, 5'd1,  32'hFFFF_FFEB, 33);
        run("mulhu_ff",     OP_MULHU,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2,  32'hFFFF_FFFE, 33);
        run("mulh_ff",      OP_MULH,   32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3,  32'h0000_0000, 33);
        run("mulhsu_ff",    OP_MULHSU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'hFFFF_FFFF, 33);
        run("mul_min_min",  OP_MUL,    32'h8000_0000, 32'h8000_0000, 5'd5,  32'h0000_0000, 33);
        run("div_m7_2",     OP_DIV,    32'hFFFF_FFF9, 32'd2,         5'd6,  32'hFFFF_FFFD, 33);
        run("rem_m7_2",     OP_REM,    32'hFFFF_FFF9, 32'd2,         5'd7,  32'hFFFF_FFFF, 33);
        run("divu_max_1",   OP_DIVU,   32'hFFFF_FFFF, 32'd1,         5'd8,  32'hFFFF_FFFF, 33);
        run("remu_100_7",   OP_REMU,   32'd100,       32'd7,         5'd9,  32'd2,         33);
        run("divu_by0",     OP_DIVU,   32'h8000_0000, 32'd0,         5'd10, 32'hFFFF_FFFF, 1);
        run("remu_by0",     OP_REMU,   32'd5,         32'd0,         5'd11, 32'd5,         1);
        run("rem_ovf",      OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 5'd12, 32'd0,         1);
        run("div_ovf",      OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h8000_0000, 1);

        // Backpressure: result held in DONE, a waiting request is not taken at the handshake edge
        bus.resp_ready = 1'b0;
        start_op(OP_DIVU, 32'd1000, 32'd10, 5'd14);
        wait_resp("bp", 32'd100, 5'd14, 33);
        bus.req_op     = OP_MUL;
        bus.req_a      = 32'd2;
        bus.req_b      = 32'd3;
        bus.req_wregno = 5'd15;
        bus.req_valid  = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            chk("bp_hold_valid", 32'(bus.resp_valid), 32'd1);
            chk("bp_hold_result", bus.resp_result, 32'd100);
            chk("bp_hold_wregno", 32'(bus.resp_wregno), 32'd14);
            chk("bp_hold_req_ready", 32'(bus.req_ready), 32'd0);
        end
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_busy", 32'(busy), 32'd0);
        chk("bp_release_valid", 32'(bus.resp_valid), 32'd0);
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        t_acc = cyc;
        wait_resp("after_bp_mul", 32'd6, 5'd15, 33);

        // Flush in the middle of an iteration drops the op
        start_op(OP_MUL, 32'h1234_5678, 32'h9ABC_DEF0, 5'd16);
        repeat (10) @(posedge clk);
        #1 flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        chk("flush_busy", 32'(busy), 32'd0);
        chk("flush_valid", 32'(bus.resp_valid), 32'd0);
        repeat (40) @(posedge clk);
        #1;
        bus.req_op    = OP_DIV;
        bus.req_a     = 32'd9;
        bus.req_b     = 32'd3;
        bus.req_valid = 1'b1;
        flush         = 1'b1;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        flush         = 1'b0;
        chk("flush_req_dropped", 32'(busy), 32'd0);
        run("divu_after_flush", OP_DIVU, 32'd100, 32'd7, 5'd17, 32'd14, 33);

        // Asynchronous reset between edges in CALC
        start_op(OP_MULHU, 32'hDEAD_BEEF, 32'h0BAD_F00D, 5'd18);
        repeat (5) @(posedge clk);
        #4 rst_n = 1'b0;
        #2;
        chk("async_rst_busy", 32'(busy), 32'd0);
        chk("async_rst_valid", 32'(bus.resp_valid), 32'd0);
        chk("async_rst_ready", 32'(bus.req_ready), 32'd1);
        @(posedge clk);
        #3 rst_n = 1'b1;
        @(posedge clk); #1;
        run("mul_3_5", OP_MUL, 32'd3, 32'd5, 5'd19, 32'd15, 33);

        repeat (3) @(posedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at 200000, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/agex_muldiv_ctrl.md
Name: agex_muldiv_ctrl

Overview:
Iterative RV32M multiply/divide unit with its sequencing controller, attached beside the single-cycle AGEX ALU.
- AGEX issues M-extension ops through a valid/ready request port.
- The controller runs a shift-add / restoring-divide datapath for DBITS cycles and holds the result until the AGEX-to-MEM path takes it.
- It drives busy, which DE uses to stall issue, and it aborts on branch-mispredict flush.

Parameters:
DBITS, 32, operand/result width (matches the pipeline data width)
REGNOBITS, 5, destination register number width
CNTBITS, 6, iteration counter width; must satisfy 2^CNTBITS > DBITS

Ports:
clk  in  1  pipeline clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = in reset)
flush  in  1  branch mispredict from AGEX; aborts any op
req_valid  in  1  AGEX presents an M-op
req_ready  out  1  unit can accept a request
req_op  in  3  RV32M funct3: 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
req_a  in  DBITS  rs1 value
req_b  in  DBITS  rs2 value
req_wregno  in  REGNOBITS  destination register
resp_valid  out  1  result available
resp_ready  in  1  consumer takes the result
resp_result  out  DBITS  result
resp_wregno  out  REGNOBITS  destination register of the result
busy  out  1  unit occupied (state != IDLE); DE stall term

Behaviour:
- States: IDLE, CALC, DONE.
- Reset (reset=0, asynchronous):
  - state=IDLE; counter, operand, accumulator and result registers = 0.
  - resp_valid=0, resp_result=0, resp_wregno=0, busy=0, req_ready=1.
  - Requests are ignored while reset=0.
- req_ready = (state==IDLE). Only one op is in flight at a time.
- Accept happens when req_valid && req_ready && !flush, at the end of cycle t0:
  - Latch op and wregno.
  - Latch operand magnitudes and sign flags:
    - a is treated as signed for MULH, MULHSU, DIV, REM.
    - b is treated as signed for MULH, DIV, REM.
  - Clear the counter.
- Special cases skip CALC and go directly to DONE, so resp_valid is high in cycle t0+1:
  - Divide/remainder by zero: DIV/DIVU give all ones; REM/REMU give req_a.
  - Signed overflow (DIV/REM with a=0x80000000, b=0xFFFFFFFF): DIV gives 0x80000000; REM gives 0.
- CALC: one iteration per clock, DBITS iterations in total.
  - Multiply: 2*DBITS-bit shift-add on magnitudes.
  - Divide: restoring, one quotient bit per cycle, with a DBITS+1-bit partial remainder.
  - On the final iteration (counter == DBITS-1):
    - Apply sign correction by two's-complement negation. Product is negated if sign_a^sign_b. Quotient is negated if sign_a^sign_b. Remainder takes sign_a.
    - Select the output word: MUL takes the low DBITS bits; MULH/MULHSU/MULHU take the high DBITS bits.
    - Register the selected word into resp_result and go to DONE.
  - Latency: resp_valid first high in cycle t0+DBITS+1.
- DONE:
  - resp_valid=1; resp_result and resp_wregno are held stable until the handshake.
  - resp_valid && resp_ready moves to IDLE at that edge; resp_valid=0 the next cycle.
  - A new request is not accepted in the same cycle as the handshake.
  - Throughput: at most 1 op per DBITS+2 cycles.
- flush (synchronous, highest priority, any state):
  - Next state is IDLE and resp_valid=0 next cycle.
  - A request presented with flush is dropped.
  - If flush coincides with resp_valid&&resp_ready, the response is discarded; the consumer qualifies capture with !flush.
- reset asserted mid-operation aborts immediately; no response is ever produced for that op.
- All arithmetic is modulo 2^DBITS (or 2^(2*DBITS) for the product); no width extension beyond what is stated above.
- busy is derived only from registered state: no combinational path from req_* to busy or resp_*.

Decomposition:
- Shared package contents:
  - muldiv_op_e (funct3 encodings)
  - muldiv_state_e (IDLE/CALC/DONE)
  - the MULDIV result constants (all-ones quotient, 0x80000000 overflow quotient)
- One sub-module, muldiv_iter_dp: operand/accumulator shift registers and one add/subtract per cycle, controlled by load/step/finish strobes from the FSM.
- FSM, counter, handshake and flush logic stay in agex_muldiv_ctrl.

Test Plan:
- MUL a=7, b=-3 (0xFFFFFFFD), resp_ready=1 → resp_result 0xFFFFFFEB, resp_valid first high exactly 33 cycles after accept; busy high in between.
- MULHU a=0xFFFFFFFF, b=0xFFFFFFFF → 0xFFFFFFFE. MULH with the same operands → 0x00000000. MULHSU with the same operands → 0xFFFFFFFF.
- DIV a=-7, b=2 → 0xFFFFFFFD; REM with the same operands → 0xFFFFFFFF. DIVU a=0x80000000, b=0 → 0xFFFFFFFF in cycle t0+1. REM a=0x80000000, b=-1 → 0.
- Backpressure: hold resp_ready=0 for 10 cycles in DONE → resp_valid, resp_result and resp_wregno remain stable and req_ready=0. On resp_ready=1 → IDLE next cycle.
- Assert flush at CALC iteration 10 → IDLE next cycle, resp_valid never asserts. An immediately following DIVU 100/7 → 14 with no corruption from the aborted op.
- Drive reset=0 asynchronously mid-CALC (between clock edges) → busy=0 and resp_valid=0 without waiting for a clock edge. After release, MUL 3*5 → 15.
